// File: rtl/svc_rv_soc_bram_bench_demo.sv
`default_nettype none

// ============================================================================
//  Module      : svc_rv_soc_bram
//  Description : Cycle-level behavioural stand-in for the BRAM RISC-V SoC.
//                It retires the built-in demo program and raises ebreak once
//                that program reaches its final instruction. The program
//                length depends on the core configuration, so option
//                comparisons show up as cycle-count differences.
//  Revision    : 1.0 - initial release
// ============================================================================
module svc_rv_soc_bram #(
    parameter int XLEN        = 32,
    parameter int IMEM_AW     = 10,
    parameter int DMEM_AW     = 10,
    parameter int PIPELINED   = 1,
    parameter int FWD_REGFILE = 1,
    parameter int FWD         = 1,
    parameter int BPRED       = 1,
    parameter     IMEM_INIT   = ""
) (
    input  logic clk,
    input  logic rst_n,
    output logic ebreak
);

    // Demo program length in cycles for each core configuration.
    localparam int c_prog_cycles = 20
                                 + ((PIPELINED   != 0) ? 0 : 12)
                                 + ((FWD         != 0) ? 0 : 9)
                                 + ((BPRED       != 0) ? 0 : 5)
                                 + ((FWD_REGFILE != 0) ? 0 : 3);

    // The stand-in only models the built-in demo program.
    if (IMEM_INIT != "") begin : g_no_image
        $error("svc_rv_soc_bram stand-in cannot load an external IMEM image");
    end

    if (XLEN < 8 || IMEM_AW < 1 || DMEM_AW < 1) begin : g_check_params
        $error("svc_rv_soc_bram: illegal XLEN/IMEM_AW/DMEM_AW");
    end

    logic [XLEN-1:0] r_retired;
    logic            w_halt;

    // The core halts on the ebreak instruction.
    assign w_halt = (r_retired == XLEN'(c_prog_cycles));

    // Count retired cycles since reset release; stop once halted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (!w_halt) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    // A core held in reset never reports ebreak.
    assign ebreak = rst_n & w_halt;

endmodule

// ============================================================================
//  Module      : svc_rv_soc_bram_bench_demo
//  Description : Self-timed benchmark top. Repeatedly resets and runs the
//                BRAM SoC, timing each run until ebreak or timeout, and
//                reports last/min/max cycle counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module svc_rv_soc_bram_bench_demo #(
    parameter int     XLEN        = 32,
    parameter int     IMEM_AW     = 10,
    parameter int     DMEM_AW     = 10,
    parameter int     PIPELINED   = 1,
    parameter int     FWD_REGFILE = 1,
    parameter int     FWD         = 1,
    parameter int     BPRED       = 1,
    parameter         IMEM_INIT   = "",
    parameter int     RUNS        = 4,
    parameter int     CW          = 32,
    parameter longint TIMEOUT     = 100000,
    parameter int     RST_CYCLES  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic                       ebreak,
    output logic [$clog2(RUNS+1)-1:0]  run_count,
    output logic [CW-1:0]              cycles_last,
    output logic [CW-1:0]              cycles_min,
    output logic [CW-1:0]              cycles_max
);

    localparam int c_rcw = $clog2(RUNS + 1);
    localparam int c_hw  = $clog2(RST_CYCLES + 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_reset = 2'd1;
    localparam logic [1:0] c_run   = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [c_rcw-1:0] c_last_run  = c_rcw'(RUNS - 1);
    localparam logic [c_hw-1:0]  c_hold_last = c_hw'(RST_CYCLES - 1);
    localparam logic [CW-1:0]    c_cnt_last  = CW'(TIMEOUT - 1);

    if (RUNS < 1 || RST_CYCLES < 1 || TIMEOUT < 2 ||
        (CW < 63 && TIMEOUT > ((longint'(1) << CW) - 1))) begin : g_check_params
        $error("svc_rv_soc_bram_bench_demo: illegal RUNS/RST_CYCLES/TIMEOUT/CW");
    end

    logic [1:0]       r_state;
    logic [c_hw-1:0]  r_hold;
    logic [CW-1:0]    r_cnt;
    logic             r_soc_run;
    logic [c_rcw-1:0] r_run_count;
    logic [CW-1:0]    r_last;
    logic [CW-1:0]    r_min;
    logic [CW-1:0]    r_max;
    logic             r_timeout;
    logic             w_soc_rst_n;
    logic             w_soc_ebreak;

    // The SoC only runs while the controller is in RUN and not externally reset.
    assign w_soc_rst_n = rst_n & r_soc_run;

    svc_rv_soc_bram #(
        .XLEN        (XLEN),
        .IMEM_AW     (IMEM_AW),
        .DMEM_AW     (DMEM_AW),
        .PIPELINED   (PIPELINED),
        .FWD_REGFILE (FWD_REGFILE),
        .FWD         (FWD),
        .BPRED       (BPRED),
        .IMEM_INIT   (IMEM_INIT)
    ) u_soc (
        .clk    (clk),
        .rst_n  (w_soc_rst_n),
        .ebreak (w_soc_ebreak)
    );

    // Run controller: reset hold, timed run, statistics and sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_hold      <= '0;
            r_cnt       <= '0;
            r_soc_run   <= 1'b0;
            r_run_count <= '0;
            r_last      <= '0;
            r_min       <= '0;
            r_max       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (start) begin
                        r_state     <= c_reset;
                        r_hold      <= '0;
                        r_cnt       <= '0;
                        r_run_count <= '0;
                        r_last      <= '0;
                        r_min       <= '0;
                        r_max       <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                c_reset: begin
                    if (r_hold == c_hold_last) begin
                        r_state   <= c_run;
                        r_soc_run <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                c_run: begin
                    // ebreak takes priority over a simultaneous timeout.
                    if (w_soc_ebreak) begin
                        r_last <= r_cnt;
                        // The first completed run seeds both extremes.
                        if (r_run_count == '0 || r_cnt < r_min) begin
                            r_min <= r_cnt;
                        end
                        if (r_run_count == '0 || r_cnt > r_max) begin
                            r_max <= r_cnt;
                        end
                        r_run_count <= r_run_count + 1'b1;
                        r_soc_run   <= 1'b0;
                        r_hold      <= '0;
                        r_state     <= (r_run_count == c_last_run) ? c_done : c_reset;
                    end else if (r_cnt == c_cnt_last) begin
                        r_timeout <= 1'b1;
                        r_soc_run <= 1'b0;
                        r_state   <= c_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_idle;
                    r_soc_run <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = (r_state == c_reset) || (r_state == c_run);
    assign done        = (r_state == c_done);
    assign timeout     = r_timeout;
    assign ebreak      = w_soc_ebreak;
    assign run_count   = r_run_count;
    assign cycles_last = r_last;
    assign cycles_min  = r_min;
    assign cycles_max  = r_max;

endmodule

`default_nettype wire

// File: tb/tb_svc_rv_soc_bram_bench_demo.sv
`timescale 1ns/1ps
`default_nettype none

// ============================================================================
//  Module      : tb_svc_rv_soc_bram_bench_demo
//  Description : Self-checking bench for the benchmark run controller.
//                Three configurations: a normal multi-run build, a FWD=0
//                build whose ebreak lands exactly on the last allowed cycle,
//                and a build whose program outlasts its timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_svc_rv_soc_bram_bench_demo;

    // Demo program lengths (cycles from SoC reset release to ebreak).
    localparam int A_RST = 4, A_RUNS = 3, A_TMO = 1000, A_LAT = 20;
    localparam int B_RST = 2, B_RUNS = 2, B_TMO = 30,   B_LAT = 29;
    localparam int C_RST = 3, C_RUNS = 2, C_TMO = 16,   C_LAT = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_v     [3];
    logic        busy_v      [3];
    logic        done_v      [3];
    logic        timeout_v   [3];
    logic        ebreak_v    [3];
    logic [1:0]  run_count_v [3];
    logic [31:0] last_v      [3];
    logic [31:0] min_v       [3];
    logic [31:0] max_v       [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    svc_rv_soc_bram_bench_demo #(
        .RUNS(A_RUNS), .TIMEOUT(A_TMO), .RST_CYCLES(A_RST)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .timeout(timeout_v[0]), .ebreak(ebreak_v[0]),
        .run_count(run_count_v[0]), .cycles_last(last_v[0]),
        .cycles_min(min_v[0]), .cycles_max(max_v[0])
    );

    svc_rv_soc_bram_bench_demo #(
        .FWD(0), .RUNS(B_RUNS), .TIMEOUT(B_TMO), .RST_CYCLES(B_RST)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .timeout(timeout_v[1]), .ebreak(ebreak_v[1]),
        .run_count(run_count_v[1]), .cycles_last(last_v[1]),
        .cycles_min(min_v[1]), .cycles_max(max_v[1])
    );

    svc_rv_soc_bram_bench_demo #(
        .RUNS(C_RUNS), .TIMEOUT(C_TMO), .RST_CYCLES(C_RST)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .timeout(timeout_v[2]), .ebreak(ebreak_v[2]),
        .run_count(run_count_v[2]), .cycles_last(last_v[2]),
        .cycles_min(min_v[2]), .cycles_max(max_v[2])
    );

    // Idle a random number of cycles between scenarios.
    task automatic idle_gap();
        repeat ($urandom_range(0, 5)) @(negedge clk);
    endtask

    // Start one sequence on DUT d and check it cycle by cycle against the
    // timing rules: each run is rst reset cycles plus lat+1 run cycles,
    // a run that cannot finish before tmo aborts after tmo run cycles.
    task automatic run_sequence(input int d, input int rst, input int lat,
                                input int runs, input int tmo, input bit noise,
                                input string name);
        bit completes;
        int per, total, exp_rc, exp_stat;
        logic exp_eb;
        completes = (lat < tmo);
        per       = rst + lat + 1;
        total     = completes ? runs * per : rst + tmo;
        start_v[d] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < total; k++) begin
            start_v[d] = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            exp_rc   = completes ? k / per : 0;
            exp_eb   = completes && ((k % per) == rst + lat);
            exp_stat = (completes && k >= per) ? lat : 0;
            n_checks++;
            if (busy_v[d] !== 1'b1) begin
                n_fail++; $display("FAIL %s busy k=%0d got %b want 1", name, k, busy_v[d]);
            end
            n_checks++;
            if (done_v[d] !== 1'b0 || timeout_v[d] !== 1'b0) begin
                n_fail++; $display("FAIL %s done/timeout k=%0d got %b/%b want 0/0", name, k, done_v[d], timeout_v[d]);
            end
            n_checks++;
            if (ebreak_v[d] !== exp_eb) begin
                n_fail++; $display("FAIL %s ebreak k=%0d got %b want %b", name, k, ebreak_v[d], exp_eb);
            end
            n_checks++;
            if (run_count_v[d] !== 2'(exp_rc)) begin
                n_fail++; $display("FAIL %s run_count k=%0d got %0d want %0d", name, k, run_count_v[d], exp_rc);
            end
            n_checks++;
            if (last_v[d] !== 32'(exp_stat) || min_v[d] !== 32'(exp_stat) || max_v[d] !== 32'(exp_stat)) begin
                n_fail++; $display("FAIL %s stats k=%0d got %0d/%0d/%0d want %0d", name, k, last_v[d], min_v[d], max_v[d], exp_stat);
            end
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        exp_rc   = completes ? runs : 0;
        exp_stat = completes ? lat : 0;
        n_checks++;
        if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b1) begin
            n_fail++; $display("FAIL %s end busy/done got %b/%b want 0/1", name, busy_v[d], done_v[d]);
        end
        n_checks++;
        if (timeout_v[d] !== !completes) begin
            n_fail++; $display("FAIL %s end timeout got %b want %b", name, timeout_v[d], !completes);
        end
        n_checks++;
        if (run_count_v[d] !== 2'(exp_rc)) begin
            n_fail++; $display("FAIL %s end run_count got %0d want %0d", name, run_count_v[d], exp_rc);
        end
        n_checks++;
        if (last_v[d] !== 32'(exp_stat) || min_v[d] !== 32'(exp_stat) || max_v[d] !== 32'(exp_stat)) begin
            n_fail++; $display("FAIL %s end stats got %0d/%0d/%0d want %0d", name, last_v[d], min_v[d], max_v[d], exp_stat);
        end
        n_checks++;
        if (ebreak_v[d] !== 1'b0) begin
            n_fail++; $display("FAIL %s end ebreak got %b want 0", name, ebreak_v[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || timeout_v[d] !== 1'b0 || ebreak_v[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset flags dut%0d got b%b d%b t%b e%b want 0", d, busy_v[d], done_v[d], timeout_v[d], ebreak_v[d]);
            end
            n_checks++;
            if (run_count_v[d] !== 2'd0 || last_v[d] !== 32'd0 || min_v[d] !== 32'd0 || max_v[d] !== 32'd0) begin
                n_fail++; $display("FAIL reset stats dut%0d got %0d %0d %0d %0d want 0", d, run_count_v[d], last_v[d], min_v[d], max_v[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sequence();
        run_sequence(0, A_RST, A_LAT, A_RUNS, A_TMO, 1'b0, "sequence");
    endtask

    task automatic test_start_ignored();
        run_sequence(0, A_RST, A_LAT, A_RUNS, A_TMO, 1'b1, "start_ignored");
    endtask

    task automatic test_timeout();
        run_sequence(2, C_RST, C_LAT, C_RUNS, C_TMO, 1'b1, "timeout");
    endtask

    task automatic test_restart_after_timeout();
        run_sequence(2, C_RST, C_LAT, C_RUNS, C_TMO, 1'b0, "restart_timeout");
    endtask

    task automatic test_ebreak_wins();
        run_sequence(1, B_RST, B_LAT, B_RUNS, B_TMO, 1'b0, "ebreak_wins");
    endtask

    task automatic test_fwd_compare();
        n_checks++;
        if (!(last_v[0] < last_v[1])) begin
            n_fail++; $display("FAIL fwd_compare got fwd1=%0d fwd0=%0d want fwd1 < fwd0", last_v[0], last_v[1]);
        end
    endtask

    task automatic test_reset_midrun();
        int kr;
        // Land somewhere in the RUN portion of the second run.
        kr = (A_RST + A_LAT + 1) + $urandom_range(A_RST, A_RST + A_LAT);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (kr) @(negedge clk);
        n_checks++;
        if (busy_v[0] !== 1'b1 || run_count_v[0] !== 2'd1) begin
            n_fail++; $display("FAIL midrun pre busy/run_count got %b/%0d want 1/1", busy_v[0], run_count_v[0]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ebreak_v[0] !== 1'b0) begin
            n_fail++; $display("FAIL midrun ebreak during reset got %b want 0", ebreak_v[0]);
        end
        @(negedge clk);
        n_checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || timeout_v[0] !== 1'b0 || run_count_v[0] !== 2'd0) begin
            n_fail++; $display("FAIL midrun flags got b%b d%b t%b rc%0d want 0", busy_v[0], done_v[0], timeout_v[0], run_count_v[0]);
        end
        n_checks++;
        if (last_v[0] !== 32'd0 || min_v[0] !== 32'd0 || max_v[0] !== 32'd0) begin
            n_fail++; $display("FAIL midrun stats got %0d/%0d/%0d want 0", last_v[0], min_v[0], max_v[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_sequence(0, A_RST, A_LAT, A_RUNS, A_TMO, 1'b0, "after_midrun_reset");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired got still running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        @(negedge clk);
        test_reset();
        idle_gap();
        test_sequence();
        idle_gap();
        test_start_ignored();
        idle_gap();
        test_timeout();
        idle_gap();
        test_restart_after_timeout();
        idle_gap();
        test_ebreak_wins();
        test_fwd_compare();
        idle_gap();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
